// File: rtl/buzz_pkg.sv
// Shared constants for the buzzer scheduler: source indices, FSM states,
// melody tables and halfperiod helpers.
package buzz_pkg;

  localparam int unsigned SRC_W      = 3;
  localparam int unsigned HP_W       = 24;
  localparam int unsigned TONE_CNT_W = 25;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned ENTRY_W    = 8;
  localparam int unsigned CNT_W      = 32;

  localparam int unsigned SRC_KEY    = 0;
  localparam int unsigned SRC_ACCEPT = 1;
  localparam int unsigned SRC_REJECT = 2;

  localparam logic [ENTRY_W-1:0] HP_REST = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Indexed [source]; first listed element is the highest index.
  localparam logic [2:0][IDX_W-1:0] PAT_LEN = {2'd3, 2'd3, 2'd1};

  // Indexed [source][note]; unused key slots are rests.
  localparam logic [2:0][2:0][ENTRY_W-1:0] PAT_HP = {
    {8'd120, HP_REST, 8'd120},
    {8'd40,  8'd47,   8'd60},
    {HP_REST, HP_REST, 8'd47}
  };

  function automatic logic [ENTRY_W-1:0] pat_entry(input logic [1:0] src,
                                                   input logic [IDX_W-1:0] idx);
    if ((src > 2'd2) || (idx > 2'd2)) return HP_REST;
    return PAT_HP[src][idx];
  endfunction

  function automatic logic [IDX_W-1:0] pat_last(input logic [1:0] src);
    if (src > 2'd2) return 2'd0;
    return PAT_LEN[src] - 2'd1;
  endfunction

  // Table entry shifted left, clamped to the largest 24-bit halfperiod.
  function automatic logic [HP_W-1:0] sat_hp(input logic [ENTRY_W-1:0] e,
                                             input int unsigned sh);
    logic [31:0] wide;
    if (e == HP_REST) return '0;
    if (sh >= 32'd24) return '1;
    wide = 32'(e) << sh;
    if (wide[31:24] != 8'd0) return '1;
    return wide[HP_W-1:0];
  endfunction

endpackage

// File: rtl/buzz_tone_gen.sv
// Square-wave generator: high for hp clocks, low for hp clocks, restarted on
// every load; a halfperiod of zero keeps the output silent.
module buzz_tone_gen
  import buzz_pkg::*;
(
  input  logic            hwclk,
  input  logic            hwrst_n,
  input  logic            load,
  input  logic [HP_W-1:0] hp,
  output logic            buzz
);

  logic [HP_W-1:0]       hp_q, hp_d;
  logic [TONE_CNT_W-1:0] cnt_q, cnt_d;
  logic [TONE_CNT_W-1:0] wrap_c;
  logic                  buzz_q, buzz_d;

  always_comb begin
    hp_d   = load ? hp : hp_q;
    wrap_c = {hp_q, 1'b0} - TONE_CNT_W'(1);
    if (load || (hp_q == '0) || (cnt_q == wrap_c)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TONE_CNT_W'(1);
    end
    // Computed from next-state values so buzz lines up with the counter.
    buzz_d = (cnt_d < {1'b0, hp_d}) && (hp_d != '0);
  end

  always_ff @(posedge hwclk or negedge hwrst_n) begin
    if (!hwrst_n) begin
      hp_q   <= '0;
      cnt_q  <= '0;
      buzz_q <= 1'b0;
    end else begin
      hp_q   <= hp_d;
      cnt_q  <= cnt_d;
      buzz_q <= buzz_d;
    end
  end

  assign buzz = buzz_q;

endmodule

// File: rtl/buzz_sched.sv
// Buzzer pattern scheduler: latches key/accept/reject requests, plays the
// highest-priority melody note by note. BUZZ_PREEMPT_EN enables abort on a
// higher-priority request.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int unsigned NOTE_CYC = 6_000_000,
  parameter int unsigned GAP_CYC  = 600_000,
  parameter int unsigned HP_SHIFT = 0
) (
  input  logic             hwclk,
  input  logic             hwrst_n,
  input  logic [SRC_W-1:0] req,
  output logic             buzz,
  output logic             busy,
  output logic [SRC_W-1:0] gnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   pend_q, pend_d;
  logic [1:0]         src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [1:0]         sel_c;
  logic [IDX_W-1:0]   next_idx_c;
  logic               start_c;
  logic               load_c;
  logic [HP_W-1:0]    hp_c;

  // Fixed priority: reject > accept > key.
  always_comb begin
    sel_c = 2'(SRC_KEY);
    if (pend_q[SRC_ACCEPT]) sel_c = 2'(SRC_ACCEPT);
    if (pend_q[SRC_REJECT]) sel_c = 2'(SRC_REJECT);
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | req;
    src_d      = src_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    done_d     = 1'b0;
    load_c     = 1'b0;
    hp_c       = '0;
    start_c    = 1'b0;
    next_idx_c = idx_q + 2'd1;

    unique case (state_q)
      ST_IDLE: start_c = |pend_q;
      ST_PLAY: begin
        if (cnt_q == NOTE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          load_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == pat_last(src_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PLAY;
            idx_d   = next_idx_c;
            load_c  = 1'b1;
            hp_c    = sat_hp(pat_entry(src_q, next_idx_c), HP_SHIFT);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BUZZ_PREEMPT_EN
    if ((state_q != ST_IDLE) && (|pend_q) && (sel_c > src_q)) start_c = 1'b1;
`endif

    // Pattern start; a same-edge request from the granted source is absorbed.
    if (start_c) begin
      state_d = ST_PLAY;
      src_d   = sel_c;
      idx_d   = '0;
      cnt_d   = '0;
      gnt_d   = 3'(1) << sel_c;
      pend_d  = (pend_q | req) & ~gnt_d;
      done_d  = 1'b0;
      load_c  = 1'b1;
      hp_c    = sat_hp(pat_entry(sel_c, 2'd0), HP_SHIFT);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge hwclk or negedge hwrst_n) begin
    if (!hwrst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      src_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  buzz_tone_gen u_tone (
    .hwclk   (hwclk),
    .hwrst_n (hwrst_n),
    .load    (load_c),
    .hp      (hp_c),
    .buzz    (buzz)
  );

  assign busy = busy_q;
  assign gnt  = gnt_q;
  assign done = done_q;

endmodule

// File: doc/buzz_sched.md
BUZZ_SCHED -- requirements
Module: buzz_sched

Interface
REQ-001 Parameter NOTE_CYC, default 6_000_000, sets clocks per note (0.5 s at 12 MHz).
REQ-002 Parameter GAP_CYC, default 600_000, sets silent clocks after each note.
REQ-003 Parameter HP_SHIFT, default 0, gives effective halfperiod = table entry << HP_SHIFT.
REQ-004 hwclk  in  1  sole clock, rising edge.
REQ-005 hwrst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  3  one-cycle request pulses: [0] key click, [1] accept melody, [2] reject melody.
REQ-007 buzz  out  1  square-wave drive to buzzer.
REQ-008 busy  out  1  high while a pattern plays (PLAY or GAP).
REQ-009 gnt  out  3  one-hot, one-cycle pulse when a pattern starts.
REQ-010 done  out  1  one-cycle pulse when a pattern completes normally.

Function
REQ-011 Each req bit SHALL be latched into pending[2:0] at the edge it is sampled high; pending SHALL clear only on grant of that source.
REQ-012 A req pulse arriving on the same edge that its source is granted SHALL be absorbed, not re-queued.
REQ-013 Arbitration SHALL be fixed priority: reject > accept > key.
REQ-014 FSM states SHALL be IDLE, PLAY and GAP.
REQ-015 Transition IDLE->PLAY: pending nonzero at edge k; note 0 loads at edge k; gnt is high for the following cycle.
REQ-016 In PLAY, the FSM SHALL hold exactly NOTE_CYC cycles, then enter GAP.
REQ-017 In GAP, buzz SHALL be 0 for exactly GAP_CYC cycles; the FSM then loads the next note into PLAY, or, after the last note, pulses done and returns to IDLE.
REQ-018 A request pending at pattern end SHALL start after exactly one IDLE cycle.
REQ-019 Patterns:
  - key = {47}
  - accept = {60, 47, 40}
  - reject = {120, 0, 120}
  - entry 0 = rest (buzz 0 for the whole PLAY).
REQ-020 The tone counter SHALL reset to 0 on every note load and count 0..2*hp-1, wrapping.
REQ-021 buzz SHALL equal (counter < hp) AND (hp != 0), registered.
REQ-022 hp SHALL be 24 bits, the counter 25 bits, and the shifted entry SHALL saturate at 24 bits.
REQ-023 Same-source request during playback SHALL queue and replay afterwards.

Reset
REQ-024 hwrst_n low SHALL immediately force the following, with no completion or done pulse:
  - buzz = 0, busy = 0, gnt = 0, done = 0
  - pending = 0, FSM = IDLE
  - all counters = 0.
REQ-025 The first edge after release SHALL sample req normally.

Configuration
REQ-026 With BUZZ_PREEMPT_EN defined, a pending source of higher priority than the playing one SHALL abort the current pattern at the next edge:
  - the new pattern starts in PLAY with its gnt pulse
  - no done pulse for the aborted pattern
  - the aborted request is not re-queued.
REQ-027 Without BUZZ_PREEMPT_EN, higher-priority requests SHALL wait in pending until the current pattern completes.

Structure
REQ-028 A shared package buzz_pkg SHALL hold:
  - the source index constants
  - the FSM state enum
  - pattern lengths and halfperiod tables
  - the rest-code constant.
REQ-029 Tone generation SHALL live in sub-module buzz_tone_gen (inputs: hwclk, hwrst_n, load, hp[23:0]; output: buzz).

Verification (NOTE_CYC=400, GAP_CYC=20, HP_SHIFT=0)
REQ-030 Reset: hold hwrst_n low mid-note, with buzz high -> buzz, busy, gnt and done all 0 in the same cycle; no done pulse after release.
REQ-031 Key: req=001 pulse:
  - gnt=001 for 1 cycle
  - buzz high 47 / low 47 cycles, repeating
  - done pulses 420 cycles after gnt.
REQ-032 Accept: req=010 -> hp sequence 60, 47, 40, each 400 cycles plus 20 silent; busy is 1260 cycles; done once.
REQ-033 Simultaneous: req=101 -> gnt=100 first; then, after reject's done and 1 IDLE cycle, gnt=001.
REQ-034 Rest: reject pattern -> buzz stays 0 through the middle 400-cycle note.
REQ-035 Preempt: req key, then req reject 100 cycles after gnt:
  - with BUZZ_PREEMPT_EN: gnt=100 next cycle, no done for key
  - without it: reject starts 1 cycle after key's done.
